// File: rtl/demod_pkg.sv
// demod_pkg: shared types, constants and the carrier-activity helper for the
// FSK demodulator (demodulador) and its sign-vote sub-block.
package demod_pkg;

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} demod_state_t;

  localparam logic [7:0] AMOSTRA_ZERO = 8'd128;
  localparam int         AMOSTRAS_BIT = 32;
  localparam logic [4:0] FASE_A       = 5'd8;
  localparam logic [4:0] FASE_B       = 5'd24;
  localparam logic [4:0] FASE_FIM     = 5'(AMOSTRAS_BIT - 1);

  // True when |a - 128| > thr, evaluated 9-bit signed so 0 and 255 do not wrap.
  function automatic logic f_ativo(input logic [7:0] a, input logic [8:0] thr);
    logic signed [8:0] d;
    logic [8:0]        m;
    d = $signed({1'b0, a}) - $signed({1'b0, AMOSTRA_ZERO});
    if (d < 9'sd0) begin
      m = unsigned'(-d);
    end else begin
      m = unsigned'(d);
    end
    return (m > thr);
  endfunction

endpackage

// File: rtl/demodulador_sign_vote.sv
// sign_vote: majority of the current sample sign and the two previous signs.
// Used by demodulador only when DEMOD_MAJORITY_EN is defined.
module sign_vote (
  input  logic clk,
  input  logic rst,
  input  logic i_sinal,
  output logic o_maioria
);

  logic [1:0] r_hist;

  // Two-deep history of sample signs, oldest in bit 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= 2'b00;
    end else begin
      r_hist <= {r_hist[0], i_sinal};
    end
  end

  assign o_maioria = (r_hist[1] & r_hist[0]) |
                     (r_hist[1] & i_sinal)   |
                     (r_hist[0] & i_sinal);

endmodule

// File: rtl/demodulador.sv
// demodulador: FSK receiver. Detects carrier start, slices 32-sample bit
// windows, decides each bit from the signs at phases 8 and 24, and assembles
// bytes LSB-first. Optional macro DEMOD_MAJORITY_EN replaces the single-sample
// signs with a 3-sample majority centred on phases 8 and 24.
module demodulador
  import demod_pkg::*;
#(
  parameter int THRESH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] amostra,
  output logic [7:0] dado_out,
  output logic       byte_valid,
  output logic       status,
  output logic       erro
);

  localparam logic [8:0] W_THR = THRESH[8:0];

  demod_state_t r_state, w_state_nxt;
  logic [4:0]   r_fase, w_fase_nxt;
  logic [2:0]   r_nbit, w_nbit_nxt;
  logic [7:0]   r_shift, w_shift_nxt, w_shift_bit;
  logic         r_s8, w_s8_nxt, r_s24, w_s24_nxt;
  logic [7:0]   r_dado, w_dado_nxt;
  logic         r_valid, w_valid_nxt, r_erro, w_erro_nxt, r_status;
  logic         w_ativo, w_sinal_sel, w_bit;

  assign w_ativo = f_ativo(amostra, W_THR);

`ifdef DEMOD_MAJORITY_EN
  // The vote needs the sample after the centre phase, so latch one phase late.
  localparam logic [4:0] FASE_S8  = FASE_A + 5'd1;
  localparam logic [4:0] FASE_S24 = FASE_B + 5'd1;

  sign_vote u_sign_vote (
    .clk       (clk),
    .rst       (rst),
    .i_sinal   (amostra[7]),
    .o_maioria (w_sinal_sel)
  );
`else
  localparam logic [4:0] FASE_S8  = FASE_A;
  localparam logic [4:0] FASE_S24 = FASE_B;

  assign w_sinal_sel = amostra[7];
`endif

  // Next-state and next-output logic for the IDLE/RECV receiver.
  always_comb begin
    w_state_nxt = r_state;
    w_fase_nxt  = r_fase;
    w_nbit_nxt  = r_nbit;
    w_shift_nxt = r_shift;
    w_s8_nxt    = r_s8;
    w_s24_nxt   = r_s24;
    w_dado_nxt  = r_dado;
    w_valid_nxt = 1'b0;
    w_erro_nxt  = 1'b0;
    w_bit       = 1'b0;
    w_shift_bit = r_shift;
    case (r_state)
      IDLE: begin
        w_fase_nxt  = 5'd0;
        w_nbit_nxt  = 3'd0;
        w_shift_nxt = 8'd0;
        if (w_ativo) begin
          // This sample is phase 1 of the first bit.
          w_state_nxt = RECV;
          w_fase_nxt  = 5'd2;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RECV: begin
        w_fase_nxt = r_fase + 5'd1;
        if ((r_fase == FASE_A) && !w_ativo) begin
          // Carrier gone: normal end on a byte boundary, error otherwise.
          w_state_nxt = IDLE;
          w_fase_nxt  = 5'd0;
          w_nbit_nxt  = 3'd0;
          w_shift_nxt = 8'd0;
          w_erro_nxt  = (r_nbit != 3'd0);
        end else begin
          if (r_fase == FASE_S8) begin
            w_s8_nxt = w_sinal_sel;
          end else begin
            w_s8_nxt = r_s8;
          end
          if (r_fase == FASE_S24) begin
            w_s24_nxt = w_sinal_sel;
          end else begin
            w_s24_nxt = r_s24;
          end
          if (r_fase == FASE_FIM) begin
            w_bit       = ~(r_s8 ^ r_s24);
            w_shift_bit = r_shift | ({7'd0, w_bit} << r_nbit);
            w_nbit_nxt  = r_nbit + 3'd1;
            if (r_nbit == 3'd7) begin
              w_dado_nxt  = w_shift_bit;
              w_valid_nxt = 1'b1;
              w_shift_nxt = 8'd0;
            end else begin
              w_shift_nxt = w_shift_bit;
            end
          end else begin
            w_shift_nxt = r_shift;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_fase   <= 5'd0;
      r_nbit   <= 3'd0;
      r_shift  <= 8'd0;
      r_s8     <= 1'b0;
      r_s24    <= 1'b0;
      r_dado   <= 8'd0;
      r_valid  <= 1'b0;
      r_erro   <= 1'b0;
      r_status <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_fase   <= w_fase_nxt;
      r_nbit   <= w_nbit_nxt;
      r_shift  <= w_shift_nxt;
      r_s8     <= w_s8_nxt;
      r_s24    <= w_s24_nxt;
      r_dado   <= w_dado_nxt;
      r_valid  <= w_valid_nxt;
      r_erro   <= w_erro_nxt;
      r_status <= (w_state_nxt == RECV);
    end
  end

  assign dado_out   = r_dado;
  assign byte_valid = r_valid;
  assign status     = r_status;
  assign erro       = r_erro;

endmodule

// File: tb/tb_demodulador.sv
// tb_demodulador: builds a sample stream from a behavioural FSK modulator,
// predicts every output cycle from bit-window arithmetic, and checks the DUT.
module tb_demodulador;

  localparam int  THRESH = 32;
  localparam real PI     = 3.14159265358979;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] amostra;
  logic [7:0] dado_out;
  logic       byte_valid, status, erro;

  always #5 clk = ~clk;

  demodulador #(.THRESH(THRESH)) dut (
    .clk        (clk),
    .rst        (rst),
    .amostra    (amostra),
    .dado_out   (dado_out),
    .byte_valid (byte_valid),
    .status     (status),
    .erro       (erro)
  );

  logic [7:0] smp[$];
  bit         rq[$];
  logic [7:0] fq[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] obs_bytes[$];
  bit         e_valid[], e_status[], e_erro[];
  logic [7:0] e_byte[], v_byte[];
  int         errs = 0;
  int         checks = 0;

  function automatic bit ativo(input logic [7:0] x);
    int d;
    d = int'(x) - 128;
    if (d < 0) d = -d;
    return d > THRESH;
  endfunction

  // Sign seen by the receiver for the window sample at stream index i.
  function automatic bit sinal_em(input int i);
`ifdef DEMOD_MAJORITY_EN
    int n;
    n = int'(smp[i-1][7]) + int'(smp[i][7]) + int'(smp[i+1][7]);
    return n >= 2;
`else
    return smp[i][7];
`endif
  endfunction

  // Modulator: bit 0 = full sine, bit 1 = half sine with alternating polarity.
  task automatic build_frame(input int nbytes, input logic [31:0] data);
    int  pol, x;
    real v;
    bit  b;
    fq.delete();
    pol = 1;
    for (int k = 0; k < nbytes * 8; k++) begin
      b = data[k];
      for (int p = 0; p < 32; p++) begin
        if (!b) v = 127.0 * $sin(2.0 * PI * p / 32.0);
        else    v = pol * 127.0 * $sin(PI * p / 32.0);
        x = 128 + int'(v) + int'($urandom_range(4, 0)) - 2;
        if (x < 0)   x = 0;
        if (x > 255) x = 255;
        fq.push_back(x[7:0]);
      end
      if (b) pol = -pol;
    end
  endtask

  function automatic int first_act();
    for (int i = 0; i < fq.size(); i++) if (ativo(fq[i])) return i;
    return 0;
  endfunction

  task automatic emit(input int keep);
    for (int i = 0; i < keep; i++) begin
      smp.push_back(fq[i]);
      rq.push_back(1'b0);
    end
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) begin
      smp.push_back(8'd128);
      rq.push_back(r);
    end
  endtask

  initial begin
    int n, t, s, lim, k, base, p8, d, stat_end, j, cut, nb, nerro;
    bit fim, bt;
    logic [7:0]  acc, dd;
    logic [31:0] rd;

    // ---------------- stimulus construction ----------------
    idle(4, 1'b1);
    idle(500, 1'b0);
    build_frame(2, 32'h0000_3CA5); emit(fq.size());
    exp_bytes.push_back(8'hA5); exp_bytes.push_back(8'h3C);
    idle(64, 1'b0);
    build_frame(2, 32'h0000_FF00); emit(fq.size());
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'hFF);
    idle(64, 1'b0);
    build_frame(1, 32'h0000_00E7); emit(32 * 4);   // carrier cut after bit 3
    idle(64, 1'b0);
    build_frame(1, 32'h0000_005A); emit(fq.size());
    exp_bytes.push_back(8'h5A);
    idle(64, 1'b0);
    build_frame(1, 32'h0000_0077);
    j   = first_act();
    cut = j - 1 + 32 * 5 + 20;                      // phase 20 of bit 5
    emit(cut);
    smp.push_back(fq[cut]); rq.push_back(1'b1);
    idle(64, 1'b0);
    build_frame(1, 32'h0000_00C3); emit(fq.size());
    exp_bytes.push_back(8'hC3);
    idle(64, 1'b0);
    build_frame(1, 32'h0000_0096);
    j = first_act();
    fq[j - 1 + 96 + 8] = fq[j - 1 + 96 + 8][7] ? 8'd20 : 8'd236;
    emit(fq.size());
`ifdef DEMOD_MAJORITY_EN
    exp_bytes.push_back(8'h96);
`else
    exp_bytes.push_back(8'h9E);
`endif
    idle(64, 1'b0);
    for (int r = 0; r < 3; r++) begin
      nb = int'($urandom_range(3, 1));
      rd = $urandom;
      build_frame(nb, rd); emit(fq.size());
      for (int b = 0; b < nb; b++) exp_bytes.push_back(rd[8*b +: 8]);
      idle(int'($urandom_range(100, 40)), 1'b0);
    end

    // ---------------- reference model ----------------
    n = smp.size();
    e_valid = new[n]; e_status = new[n]; e_erro = new[n];
    e_byte  = new[n]; v_byte   = new[n];
    for (int i = 0; i < n; i++) begin
      e_valid[i] = 1'b0; e_status[i] = 1'b0; e_erro[i] = 1'b0; v_byte[i] = 8'd0;
    end
    t = 0;
    while (t < n) begin
      if (rq[t] || !ativo(smp[t])) begin
        t++;
      end else begin
        s = t;
        lim = n;
        for (int i = s + 1; i < n; i++) if (rq[i]) begin lim = i; break; end
        acc = 8'd0; k = 0; fim = 1'b0; stat_end = n;
        while (!fim) begin
          base = s - 1 + 32 * k;
          p8   = base + 8;
          d    = base + 31;
          if (p8 >= lim) begin
            stat_end = lim; t = lim + 1; fim = 1'b1;
          end else if (!ativo(smp[p8])) begin
            stat_end = p8; e_erro[p8] = (k % 8 != 0); t = p8 + 1; fim = 1'b1;
          end else if (d >= lim) begin
            stat_end = lim; t = lim + 1; fim = 1'b1;
          end else begin
            bt = (sinal_em(p8) == sinal_em(base + 24));
            acc[k % 8] = bt;
            if (k % 8 == 7) begin
              e_valid[d] = 1'b1; v_byte[d] = acc; acc = 8'd0;
            end
            k++;
          end
        end
        for (int i = s; i < stat_end; i++) e_status[i] = 1'b1;
      end
    end
    dd = 8'd0;
    for (int i = 0; i < n; i++) begin
      if (rq[i]) dd = 8'd0;
      else if (e_valid[i]) dd = v_byte[i];
      e_byte[i] = dd;
    end

    // ---------------- drive and check ----------------
    nerro = 0;
    rst = 1'b1; amostra = 8'd128;
    for (int e = 0; e < n; e++) begin
      amostra = smp[e];
      rst     = rq[e];
      @(posedge clk);
      #1;
      checks++;
      assert (dado_out === e_byte[e]) else begin
        errs++; $error("FAIL dado_out cyc=%0d got=%h exp=%h", e, dado_out, e_byte[e]);
      end
      checks++;
      assert (byte_valid === e_valid[e]) else begin
        errs++; $error("FAIL byte_valid cyc=%0d got=%b exp=%b", e, byte_valid, e_valid[e]);
      end
      checks++;
      assert (status === e_status[e]) else begin
        errs++; $error("FAIL status cyc=%0d got=%b exp=%b", e, status, e_status[e]);
      end
      checks++;
      assert (erro === e_erro[e]) else begin
        errs++; $error("FAIL erro cyc=%0d got=%b exp=%b", e, erro, e_erro[e]);
      end
      if (byte_valid === 1'b1) obs_bytes.push_back(dado_out);
      if (erro === 1'b1) nerro++;
    end

    checks++;
    assert (obs_bytes.size() === exp_bytes.size()) else begin
      errs++; $error("FAIL byte_count got=%0d exp=%0d", obs_bytes.size(), exp_bytes.size());
    end
    for (int i = 0; i < exp_bytes.size(); i++) begin
      if (i < obs_bytes.size()) begin
        checks++;
        assert (obs_bytes[i] === exp_bytes[i]) else begin
          errs++; $error("FAIL byte_seq idx=%0d got=%h exp=%h", i, obs_bytes[i], exp_bytes[i]);
        end
      end
    end
    checks++;
    assert (nerro === 1) else begin
      errs++; $error("FAIL erro_count got=%0d exp=1", nerro);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
